// File: rtl/diag_spi_controller.sv
// SPI-slave diagnostics port: CPU halt, RAM/VRAM access, config select.
// Optional ECHO opcode (0x08) is compiled in with `define DIAG_ECHO_EN.
module diag_spi_controller #(
  parameter int ADDR_W  = 16,
  parameter int VRAM_AW = 11,
  parameter int CFG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  output logic               halt,
  input  logic               spi_cs_n,
  input  logic               spi_clk,
  input  logic               spi_in,
  output logic               spi_out,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [7:0]         ram_rdata,
  output logic [7:0]         ram_wdata,
  output logic               ram_we,
  output logic               ram_cs,
  input  logic [CFG_W-1:0]   configuration,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [7:0]         vram_rdata,
  output logic               vram_clk,
  output logic [CFG_W-1:0]   config_byte,
  input  logic [VRAM_AW-1:0] vram_size,
  input  logic               ram_disable_in,
  output logic               ram_disable_out,
  input  logic               rom_disable_in,
  output logic               rom_disable_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_AH,
    S_RD_AL,
    S_RD_DATA,
    S_WR_AH,
    S_WR_AL,
    S_WR_DATA,
    S_VRAM,
    S_SETCFG,
    S_ECHO,
    S_WAIT
  } state_t;

  logic [1:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sclk_prev_q;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          rx_sh_q, rx_sh_d;
  logic [7:0]          tx_sh_q, tx_sh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [1:0]          rd_stage_q, rd_stage_d;
  logic                halt_q, halt_d;
  logic                ram_cs_q, ram_cs_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic [VRAM_AW-1:0]  vram_addr_q, vram_addr_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic                ram_dis_q, ram_dis_d;
  logic                rom_dis_q, rom_dis_d;

  logic                cs_act;
  logic                mosi;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                rx_valid;
  logic [7:0]          rx_byte;
  logic [VRAM_AW-1:0]  vram_next;
  logic [7:0]          resp;
  logic                rd_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_in};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign cs_act    = ~cs_sync_q[1];
  assign mosi      = mosi_sync_q[1];
  assign sclk_rise = cs_act & sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = cs_act & ~sclk_sync_q[1] & sclk_prev_q;
  assign rx_valid  = sclk_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_sh_q, mosi};
  assign vram_next = vram_addr_q + VRAM_AW'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    addr_d      = addr_q;
    addr_hi_d   = addr_hi_q;
    rd_stage_d  = {rd_stage_q[0], 1'b0};
    halt_d      = halt_q;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    vram_addr_d = vram_addr_q;
    cfg_d       = cfg_q;
    ram_dis_d   = ram_dis_q;
    rom_dis_d   = rom_dis_q;
    resp        = 8'h00;
    rd_issue    = 1'b0;

    if (sclk_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_sh_d   = rx_byte[6:0];
    end
    // No shift on the falling edge that ends a byte: the freshly
    // loaded response MSB must survive until the next first edge.
    if (sclk_fall && bit_cnt_q != 3'd0) begin
      tx_sh_d = {tx_sh_q[6:0], 1'b0};
    end
    if (rd_stage_q[1]) begin
      tx_sh_d = ram_rdata;
    end

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          case (rx_byte)
            8'h01: halt_d = 1'b1;
            8'h02: halt_d = 1'b0;
            8'h03: state_d = S_RD_AH;
            8'h04: state_d = S_WR_AH;
            8'h05: begin
              vram_addr_d = '0;
              state_d     = S_VRAM;
            end
            8'h06: state_d = S_SETCFG;
            8'h07: resp = 8'({rom_dis_q, ram_dis_q, cfg_q});
`ifdef DIAG_ECHO_EN
            8'h08: state_d = S_ECHO;
`endif
            default: state_d = S_WAIT;
          endcase
        end
        S_RD_AH: begin
          addr_hi_d = rx_byte;
          state_d   = S_RD_AL;
        end
        S_RD_AL: begin
          addr_d   = ADDR_W'({addr_hi_q, rx_byte});
          rd_issue = 1'b1;
          state_d  = S_RD_DATA;
        end
        S_RD_DATA: begin
          addr_d   = addr_q + ADDR_W'(1);
          rd_issue = 1'b1;
        end
        S_WR_AH: begin
          addr_hi_d = rx_byte;
          state_d   = S_WR_AL;
        end
        S_WR_AL: begin
          addr_d  = ADDR_W'({addr_hi_q, rx_byte});
          state_d = S_WR_DATA;
        end
        S_WR_DATA: begin
          if (halt_q) begin
            ram_cs_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = addr_q;
            ram_wdata_d = rx_byte;
          end
          addr_d = addr_q + ADDR_W'(1);
        end
        S_VRAM: begin
          resp        = vram_rdata;
          vram_addr_d = (vram_next >= vram_size) ? '0 : vram_next;
        end
        S_SETCFG: begin
          cfg_d     = rx_byte[CFG_W-1:0];
          ram_dis_d = rx_byte[5];
          rom_dis_d = rx_byte[6];
          state_d   = S_WAIT;
        end
        S_ECHO: resp = rx_byte;
        S_WAIT: ;
        default: state_d = S_IDLE;
      endcase
      tx_sh_d = resp;
      // RAM data lands two cycles later and overwrites the zero above.
      if (rd_issue && halt_q) begin
        ram_cs_d   = 1'b1;
        ram_addr_d = addr_d;
        rd_stage_d = 2'b01;
      end
    end

    if (!cs_act) begin
      bit_cnt_d  = 3'd0;
      state_d    = S_IDLE;
      tx_sh_d    = 8'h00;
      rd_stage_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= '0;
      tx_sh_q     <= 8'h00;
      addr_q      <= '0;
      addr_hi_q   <= 8'h00;
      rd_stage_q  <= 2'b00;
      halt_q      <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h00;
      vram_addr_q <= '0;
      cfg_q       <= configuration;
      ram_dis_q   <= ram_disable_in;
      rom_dis_q   <= rom_disable_in;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      addr_q      <= addr_d;
      addr_hi_q   <= addr_hi_d;
      rd_stage_q  <= rd_stage_d;
      halt_q      <= halt_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      vram_addr_q <= vram_addr_d;
      cfg_q       <= cfg_d;
      ram_dis_q   <= ram_dis_d;
      rom_dis_q   <= rom_dis_d;
    end
  end

  assign halt            = halt_q;
  assign spi_out         = tx_sh_q[7];
  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign ram_we          = ram_we_q;
  assign ram_cs          = ram_cs_q;
  assign vram_addr       = vram_addr_q;
  assign vram_clk        = clk;
  assign config_byte     = cfg_q;
  assign ram_disable_out = ram_dis_q;
  assign rom_disable_out = rom_dis_q;

endmodule

// File: tb/tb_diag_spi_controller.sv
// Directed bench for diag_spi_controller: SPI host model, RAM/VRAM models.
// Vector table of SPI transactions plus hand-written abort/VRAM sequences.
module tb_diag_spi_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_in;
  logic        spi_out;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_cs;
  logic [4:0]  configuration;
  logic [10:0] vram_addr;
  logic [7:0]  vram_rdata;
  logic        vram_clk;
  logic [4:0]  config_byte;
  logic [10:0] vram_size;
  logic        ram_disable_in;
  logic        ram_disable_out;
  logic        rom_disable_in;
  logic        rom_disable_out;

  always #5 clk = ~clk;

  diag_spi_controller dut (
    .clk             (clk),
    .rst             (rst),
    .halt            (halt),
    .spi_cs_n        (spi_cs_n),
    .spi_clk         (spi_clk),
    .spi_in          (spi_in),
    .spi_out         (spi_out),
    .ram_addr        (ram_addr),
    .ram_rdata       (ram_rdata),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .ram_cs          (ram_cs),
    .configuration   (configuration),
    .vram_addr       (vram_addr),
    .vram_rdata      (vram_rdata),
    .vram_clk        (vram_clk),
    .config_byte     (config_byte),
    .vram_size       (vram_size),
    .ram_disable_in  (ram_disable_in),
    .ram_disable_out (ram_disable_out),
    .rom_disable_in  (rom_disable_in),
    .rom_disable_out (rom_disable_out)
  );

  logic [7:0] mem  [0:65535];
  logic [7:0] vmem [0:2047];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(posedge vram_clk) vram_rdata <= vmem[vram_addr];

  int          cs_cnt;
  int          gate_err;
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (ram_cs) cs_cnt++;
      if ((ram_cs || ram_we) && !halt) gate_err++;
      if (ram_we && !ram_cs) gate_err++;
      if (ram_we) begin
        wa_q.push_back(ram_addr);
        wd_q.push_back(ram_wdata);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_in = b[i];
      wait_clk(8);
      r[i] = spi_out;
      spi_clk = 1'b1;
      wait_clk(8);
      spi_clk = 1'b0;
    end
    wait_clk(8);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  typedef struct {
    string           name;
    int              n;
    logic [0:5][7:0] mosi;
    logic [0:5][7:0] miso;
    logic            exp_halt;
    logic [6:0]      exp_cfg;
    int              exp_cs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input int n,
                              input logic [47:0] mo,
                              input logic [47:0] mi,
                              input logic h, input logic [6:0] c,
                              input int cs);
    vec_t v;
    v.name = nm;
    v.n = n;
    v.mosi = mo;
    v.miso = mi;
    v.exp_halt = h;
    v.exp_cfg = c;
    v.exp_cs = cs;
    return v;
  endfunction

  logic [7:0] r;
  logic [7:0] ea [0:5];
  logic [7:0] er [0:5];
  int         cs0;
  logic [47:0] echo_exp;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) vmem[i] = 8'hC0 + 8'(i);
    cs_cnt = 0;
    gate_err = 0;
    ram_rdata = 8'h00;
    vram_rdata = 8'h00;

`ifdef DIAG_ECHO_EN
    echo_exp = {8'h00, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00};
`else
    echo_exp = 48'h0;
`endif

    vecs.push_back(mk("halt", 1, {8'h01, 40'h0}, 48'h0,
                      1'b1, 7'h2B, 0));
    vecs.push_back(mk("wr1234", 5,
                      {8'h04, 8'h12, 8'h34, 8'hAA, 8'h55, 8'h00},
                      48'h0, 1'b1, 7'h2B, 2));
    vecs.push_back(mk("rd1234", 5,
                      {8'h03, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00},
                      {8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h00},
                      1'b1, 7'h2B, 3));
    vecs.push_back(mk("run", 1, {8'h02, 40'h0}, 48'h0,
                      1'b0, 7'h2B, 0));
    vecs.push_back(mk("rd_run", 5,
                      {8'h03, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00},
                      48'h0, 1'b0, 7'h2B, 0));
    vecs.push_back(mk("wr_run", 4,
                      {8'h04, 8'h12, 8'h34, 8'h77, 8'h00, 8'h00},
                      48'h0, 1'b0, 7'h2B, 0));
    vecs.push_back(mk("halt2", 1, {8'h01, 40'h0}, 48'h0,
                      1'b1, 7'h2B, 0));
    vecs.push_back(mk("wrFFFF", 5,
                      {8'h04, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h00},
                      48'h0, 1'b1, 7'h2B, 2));
    vecs.push_back(mk("rdFFFF", 5,
                      {8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00},
                      {8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00},
                      1'b1, 7'h2B, 3));
    vecs.push_back(mk("setcfg", 2, {8'h06, 8'h63, 32'h0}, 48'h0,
                      1'b1, 7'h63, 0));
    vecs.push_back(mk("getcfg", 2, {8'h07, 8'h00, 32'h0},
                      {8'h00, 8'h63, 32'h0}, 1'b1, 7'h63, 0));
    vecs.push_back(mk("unknown", 3, {8'h09, 8'h01, 8'h02, 24'h0},
                      48'h0, 1'b1, 7'h63, 0));
    vecs.push_back(mk("op08", 4,
                      {8'h08, 8'h5A, 8'hA5, 8'h3C, 8'h00, 8'h00},
                      echo_exp, 1'b1, 7'h63, 0));
    vecs.push_back(mk("setcfg_b7", 2, {8'h06, 8'h8B, 32'h0}, 48'h0,
                      1'b1, 7'h0B, 0));
    vecs.push_back(mk("getcfg2", 2, {8'h07, 8'h00, 32'h0},
                      {8'h00, 8'h0B, 32'h0}, 1'b1, 7'h0B, 0));

    rst = 1'b1;
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    spi_in = 1'b0;
    configuration = 5'h0B;
    ram_disable_in = 1'b1;
    rom_disable_in = 1'b0;
    vram_size = 11'd4;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check("rst_cfg", 32'(config_byte), 32'h0B);
    check("rst_ramdis", 32'(ram_disable_out), 32'h1);
    check("rst_romdis", 32'(rom_disable_out), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_miso", 32'(spi_out), 32'h0);
    check("rst_ramcs", 32'(ram_cs), 32'h0);
    check("rst_vaddr", 32'(vram_addr), 32'h0);
    configuration = 5'h1F;
    ram_disable_in = 1'b0;
    rom_disable_in = 1'b1;
    wait_clk(4);

    foreach (vecs[k]) begin
      cs0 = cs_cnt;
      cs_low();
      for (int i = 0; i < vecs[k].n; i++) begin
        xfer(vecs[k].mosi[i], r);
        check($sformatf("%s_miso%0d", vecs[k].name, i),
              32'(r), 32'(vecs[k].miso[i]));
      end
      cs_high();
      check({vecs[k].name, "_halt"}, 32'(halt),
            32'(vecs[k].exp_halt));
      check({vecs[k].name, "_cfg"},
            32'({rom_disable_out, ram_disable_out, config_byte}),
            32'(vecs[k].exp_cfg));
      check({vecs[k].name, "_cscnt"}, 32'(cs_cnt - cs0),
            32'(vecs[k].exp_cs));
    end

    check("wr_count", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      check("wr0_addr", 32'(wa_q[0]), 32'h1234);
      check("wr0_data", 32'(wd_q[0]), 32'hAA);
      check("wr1_addr", 32'(wa_q[1]), 32'h1235);
      check("wr1_data", 32'(wd_q[1]), 32'h55);
      check("wr2_addr", 32'(wa_q[2]), 32'hFFFF);
      check("wr2_data", 32'(wd_q[2]), 32'h11);
      check("wr3_addr", 32'(wa_q[3]), 32'h0000);
      check("wr3_data", 32'(wd_q[3]), 32'h22);
    end
    check("mem1234", 32'(mem[16'h1234]), 32'hAA);

    // Abort an opcode after three bits, then a VRAM dump.
    cs_low();
    for (int i = 0; i < 3; i++) begin
      spi_in = 1'b0;
      wait_clk(8);
      spi_clk = 1'b1;
      wait_clk(8);
      spi_clk = 1'b0;
    end
    wait_clk(4);
    cs_high();
    check("abort_miso", 32'(spi_out), 32'h0);
    check("abort_halt", 32'(halt), 32'h1);

    ea = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    er = '{8'h00, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC0};
    cs0 = cs_cnt;
    cs_low();
    xfer(8'h05, r);
    check("vram_op_miso", 32'(r), 32'h0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("vaddr%0d", i), 32'(vram_addr), 32'(ea[i]));
      xfer(8'h00, r);
      check($sformatf("vdata%0d", i), 32'(r), 32'(er[i]));
    end
    cs_high();
    check("vram_halt", 32'(halt), 32'h1);
    check("vram_cfg",
          32'({rom_disable_out, ram_disable_out, config_byte}),
          32'h0B);
    check("vram_nocs", 32'(cs_cnt - cs0), 32'd0);

    vram_size = 11'd0;
    cs_low();
    xfer(8'h05, r);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("vz_addr%0d", i), 32'(vram_addr), 32'd0);
      xfer(8'h00, r);
      check($sformatf("vz_data%0d", i), 32'(r),
            (i == 0) ? 32'h00 : 32'hC0);
    end
    cs_high();

    check("gate_err", 32'(gate_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
